// File: rtl/serin_rx_if.sv
// Serial-input receiver bus bundle.
// Groups the timer strobe, raw pin, interrupt ack and all receiver status outputs.
//   slave  : the receiver (consumes bitTick/sin/irqAck, drives status/data)
//   master : the surrounding POKEY logic (timer, pin, IRQ and SKSTAT side)
interface serin_rx_if;
  logic       bitTick;    // mid-bit sample strobe from timer 4
  logic       sin;        // raw asynchronous serial pin, idle = 1
  logic       irqAck;     // clears the pending-byte flag
  logic       timerSync;  // realign timer 4 to the start edge
  logic [7:0] serinData;  // last received byte (SERIN)
  logic       serinRdy;   // byte-complete pulse (IRQST bit 5)
  logic       sdiOvrun;   // byte completed while previous still pending
  logic       setFramer;  // byte completed with stop bit = 0
  logic       sdiBusy;    // frame in progress
  logic       siDelay;    // synchronized serial input level

  modport slave (
    input  bitTick, sin, irqAck,
    output timerSync, serinData, serinRdy, sdiOvrun, setFramer, sdiBusy, siDelay
  );

  modport master (
    output bitTick, sin, irqAck,
    input  timerSync, serinData, serinRdy, sdiOvrun, setFramer, sdiBusy, siDelay
  );
endinterface

// File: rtl/serin_rx.sv
// POKEY serial-input receiver.
// Deserializes SID frames (start, 8 data bits LSB first, stop) sampled on timer-4
// ticks, holds the byte for SERIN and pulses the serial-input-ready interrupt.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : serin_rx_if.slave (bitTick, sin, irqAck in; timerSync, serinData,
//           serinRdy, sdiOvrun, setFramer, sdiBusy, siDelay out)
module serin_rx (
  input logic        clk,
  input logic        reset,
  serin_rx_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e     state_q, state_d;
  logic       sync1_q, siDelay_q, siPrev_q;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic       rxPend_q, rxPend_d;
  logic [7:0] serinData_q, serinData_d;
  logic       timerSync_q, timerSync_d;
  logic       serinRdy_q, serinRdy_d;
  logic       setFramer_q, setFramer_d;
  logic       sdiOvrun_q, sdiOvrun_d;
  logic       sdiBusy_q, sdiBusy_d;
  logic       fallEdge;
  logic       pendAcked;

  assign fallEdge = siPrev_q & ~siDelay_q;
  // Ack is applied before a same-cycle completion looks at the pending flag.
  assign pendAcked = rxPend_q & ~bus.irqAck;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fallEdge) state_d = StStart;
      StStart: if (bus.bitTick) state_d = siDelay_q ? StIdle : StData;
      StData:  if (bus.bitTick && bitCnt_q == 3'd7) state_d = StStop;
      StStop:  if (bus.bitTick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    shreg_d     = shreg_q;
    bitCnt_d    = bitCnt_q;
    serinData_d = serinData_q;
    rxPend_d    = pendAcked;
    timerSync_d = 1'b0;
    serinRdy_d  = 1'b0;
    setFramer_d = 1'b0;
    sdiOvrun_d  = 1'b0;
    unique case (state_q)
      StIdle: timerSync_d = fallEdge;
      StStart: begin
        if (bus.bitTick && !siDelay_q) bitCnt_d = 3'd0;
      end
      StData: begin
        if (bus.bitTick) begin
          shreg_d  = {siDelay_q, shreg_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
        end
      end
      StStop: begin
        // A framing error still delivers the byte and marks it pending.
        if (bus.bitTick) begin
          serinData_d = shreg_q;
          serinRdy_d  = 1'b1;
          setFramer_d = ~siDelay_q;
          sdiOvrun_d  = pendAcked;
          rxPend_d    = 1'b1;
        end
      end
      default: ;
    endcase
    sdiBusy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      siDelay_q   <= 1'b1;
      siPrev_q    <= 1'b1;
      shreg_q     <= 8'h00;
      bitCnt_q    <= 3'd0;
      rxPend_q    <= 1'b0;
      serinData_q <= 8'h00;
      timerSync_q <= 1'b0;
      serinRdy_q  <= 1'b0;
      setFramer_q <= 1'b0;
      sdiOvrun_q  <= 1'b0;
      sdiBusy_q   <= 1'b0;
    end else begin
      sync1_q     <= bus.sin;
      siDelay_q   <= sync1_q;
      siPrev_q    <= siDelay_q;
      shreg_q     <= shreg_d;
      bitCnt_q    <= bitCnt_d;
      rxPend_q    <= rxPend_d;
      serinData_q <= serinData_d;
      timerSync_q <= timerSync_d;
      serinRdy_q  <= serinRdy_d;
      setFramer_q <= setFramer_d;
      sdiOvrun_q  <= sdiOvrun_d;
      sdiBusy_q   <= sdiBusy_d;
    end
  end

  assign bus.timerSync = timerSync_q;
  assign bus.serinData = serinData_q;
  assign bus.serinRdy  = serinRdy_q;
  assign bus.setFramer = setFramer_q;
  assign bus.sdiOvrun  = sdiOvrun_q;
  assign bus.sdiBusy   = sdiBusy_q;
  assign bus.siDelay   = siDelay_q;

endmodule

// File: tb/tb_serin_rx.sv
// Self-checking bench for serin_rx: directed frames, scoreboard of expected bytes.
module tb_serin_rx;

  logic clk = 1'b0;
  logic reset;
  serin_rx_if bus ();

  serin_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       framer;
    logic       ovrun;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   rdy_cnt = 0;
  int   sync_cnt = 0;
  int   pushed = 0;
  logic tb_pend = 1'b0;   // bench model of the pending-byte flag
  logic rdy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus.irqAck = 1'b1;
    step();
    bus.irqAck = 1'b0;
    tb_pend = 1'b0;
  endtask

  // One bit period of 28 cycles with the tick 14 cycles after the bit edge.
  task automatic send_bit(input logic v, input logic ack, input logic chk_busy);
    bus.sin = v;
    repeat (13) step();
    if (chk_busy) chk("busy_in_frame", 32'(bus.sdiBusy), 32'd1);
    bus.bitTick = 1'b1;
    bus.irqAck  = ack;
    step();
    bus.bitTick = 1'b0;
    bus.irqAck  = 1'b0;
    repeat (14) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_at_stop,
                            input logic chk_busy);
    exp_t e;
    e.data   = d;
    e.framer = ~stop;
    e.ovrun  = tb_pend & ~ack_at_stop;
    sb_q.push_back(e);
    pushed++;
    tb_pend = 1'b1;
    send_bit(1'b0, 1'b0, chk_busy);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, chk_busy);
    send_bit(stop, ack_at_stop, chk_busy);
    bus.sin = 1'b1;
    repeat (4) step();
  endtask

  // Output monitor: pops the scoreboard on each completed byte.
  always @(negedge clk) begin
    exp_t e;
    if (bus.timerSync === 1'b1) sync_cnt++;
    if (bus.serinRdy === 1'b1) begin
      rdy_cnt++;
      chk("rdy_width", 32'(rdy_prev), 32'd0);
      chk("busy_fall_with_rdy", 32'(bus.sdiBusy), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_rdy", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("serinData", 32'(bus.serinData), 32'(e.data));
        chk("setFramer", 32'(bus.setFramer), 32'(e.framer));
        chk("sdiOvrun", 32'(bus.sdiOvrun), 32'(e.ovrun));
      end
    end else if (bus.setFramer === 1'b1 || bus.sdiOvrun === 1'b1) begin
      chk("flag_without_rdy", 32'(bus.serinRdy), 32'd1);
    end
    rdy_prev = (bus.serinRdy === 1'b1);
  end

  initial begin
    int sync0, rdy0;
    logic [7:0] pat;
    reset       = 1'b1;
    bus.sin     = 1'b1;
    bus.bitTick = 1'b0;
    bus.irqAck  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_serinData", 32'(bus.serinData), 32'h00);
    chk("rst_sdiBusy", 32'(bus.sdiBusy), 32'd0);
    chk("rst_siDelay", 32'(bus.siDelay), 32'd1);
    chk("rst_serinRdy", 32'(bus.serinRdy), 32'd0);
    chk("rst_timerSync", 32'(bus.timerSync), 32'd0);
    chk("rst_flags", 32'({bus.setFramer, bus.sdiOvrun}), 32'd0);

    // Normal byte
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    chk("normal_data", 32'(bus.serinData), 32'hA5);
    chk("normal_sync_cnt", 32'(sync_cnt), 32'd1);
    chk("normal_busy_after", 32'(bus.sdiBusy), 32'd0);
    ack_pulse();

    // False start
    sync0 = sync_cnt;
    rdy0  = rdy_cnt;
    bus.sin = 1'b0;
    repeat (5) step();
    bus.sin = 1'b1;
    repeat (5) step();
    chk("fs_timerSync", 32'(sync_cnt), 32'(sync0 + 1));
    chk("fs_busy_before_tick", 32'(bus.sdiBusy), 32'd1);
    repeat (3) step();
    bus.bitTick = 1'b1;
    step();
    bus.bitTick = 1'b0;
    chk("fs_busy_after_tick", 32'(bus.sdiBusy), 32'd0);
    repeat (10) step();
    chk("fs_no_rdy", 32'(rdy_cnt), 32'(rdy0));
    chk("fs_data_kept", 32'(bus.serinData), 32'hA5);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("framer_data", 32'(bus.serinData), 32'h3C);
    ack_pulse();

    // Overrun, then ack clears it
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovrun_data", 32'(bus.serinData), 32'h22);
    ack_pulse();
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);

    // Ack coincident with STOP tick: no overrun, pending stays set
    send_frame(8'h44, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    ack_pulse();

    // Reset after 4 data ticks
    pat = 8'h96;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(pat[i], 1'b0, 1'b0);
    bus.sin = pat[4];
    repeat (5) step();
    reset   = 1'b1;
    bus.sin = 1'b1;
    step();
    reset   = 1'b0;
    tb_pend = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.sdiBusy), 32'd0);
    chk("mid_rst_data", 32'(bus.serinData), 32'h00);
    chk("mid_rst_siDelay", 32'(bus.siDelay), 32'd1);
    repeat (4) step();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data", 32'(bus.serinData), 32'h5A);

    repeat (5) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("rdy_total", 32'(rdy_cnt), 32'(pushed));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serin_rx.md
# serin_rx

Serial-input receiver for the POKEY serial port. Deserializes the asynchronous SID line (start bit, 8 data bits LSB first, stop bit) at the bit rate supplied by the channel-4 timer. It holds the received byte for the SERIN register and raises the serial-input-ready interrupt. It sits directly upstream of SKSTAT_reg and drives its `sdiOvrun`, `setFramer`, `sdiBusy` and `siDelay` inputs.

## Interface

Parameters: none.

- `clk` input 1: 50 MHz system clock. One clock domain only.
- `reset` input 1: synchronous, active-high reset.
- `bitTick` input 1: mid-bit sample strobe from timer channel 4. Valid for one `clk` cycle.
- `sin` input 1: raw serial data pin. Asynchronous; idle/mark = 1.
- `irqAck` input 1: one-cycle pulse that clears the pending-byte flag. Driven by the IRQST/IRQEN clear logic.
- `timerSync` output 1: one-cycle pulse that realigns timer 4 to the start-bit edge.
- `serinData` output 8: last received byte (SERIN).
- `serinRdy` output 1: one-cycle pulse when a byte completes. Goes to IRQST bit 5.
- `sdiOvrun` output 1: one-cycle pulse when a byte completes while the previous byte is still pending.
- `setFramer` output 1: one-cycle pulse when a byte completes with stop bit = 0.
- `sdiBusy` output 1: level, high while a frame is in progress.
- `siDelay` output 1: synchronized serial input level.

## Operation

- **Synchronizer**
  - `sin` passes through two flops; the second flop is `siDelay`.
  - `siPrev` is one further flop, used for edge detection.
  - All three flops update every `clk`.
- **FSM states:** IDLE, START, DATA, STOP. A "tick" is any cycle with `bitTick` = 1.
- **IDLE**
  - Falling edge (`siPrev`=1, `siDelay`=0) → START, with a `timerSync` pulse.
  - Ticks are ignored.
- **START**
  - On a tick, `siDelay`=0 → DATA and `bitCnt` ← 0.
  - On a tick, `siDelay`=1 → false start: return to IDLE. No flags, no data change.
- **DATA**
  - On each tick, `shreg` ← {`siDelay`, `shreg`[7:1]} and `bitCnt` increments.
  - On the tick where `bitCnt`=7 (the 8th bit), go to STOP.
- **STOP**
  - On a tick, perform all of the following, then go to IDLE:
    - `serinData` ← `shreg`.
    - Pulse `serinRdy`.
    - Pulse `setFramer` if `siDelay`=0.
    - Pulse `sdiOvrun` if `rxPend`=1.
    - `rxPend` ← 1.
  - A framing error still delivers the data and still sets `rxPend`.
- **Status outputs**
  - `sdiBusy` = (state ≠ IDLE), registered.
  - `bitCnt` is 3 bits wide, wraps 7→0, and is only reloaded on entry to DATA.
- **`rxPend` clearing**
  - `irqAck` clears `rxPend`.
  - If `irqAck` and STOP completion occur in the same cycle, the ack is applied first: no `sdiOvrun`, and `rxPend` ends at 1.
- **Overrun**
  - On overrun, `serinData` is overwritten with the new byte.
- **Reset**
  - Reset mid-frame aborts the frame.
  - Reset values: state IDLE, `shreg`=0, `bitCnt`=0, `rxPend`=0, `serinData`=0x00, sync flops and `siPrev`=1 (`siDelay`=1).
  - All pulse outputs and `sdiBusy` reset to 0.

## Timing

- `sin` → `siDelay` latency: 2 `clk` cycles. Start-edge detection takes 1 more cycle.
- `timerSync` is asserted in the cycle following the first `clk` edge where `siDelay`=0 and `siPrev`=1.
- FSM transitions take effect at the `clk` edge of the tick cycle. Outputs are registered, so they appear the next cycle.
- `serinData`, `serinRdy`, `setFramer` and `sdiOvrun` change at the same edge. Pulses are exactly 1 `clk` wide.
- One frame requires exactly 10 ticks after the start edge: 1 start, 8 data, 1 stop.
- `sdiBusy` rises with `timerSync` and falls with `serinRdy`.
- Back-to-back frames: a falling edge in the cycle right after STOP→IDLE is accepted.

## Test plan

- **Normal byte.** Reset, then send start, 0xA5 LSB first, stop=1 with a tick every 28 cycles, 14 cycles after each bit edge. Expect `serinData`=0xA5, one `serinRdy` pulse, no `setFramer`/`sdiOvrun`, and `sdiBusy` high for the whole frame.
- **False start.** Drive a 0 glitch that returns to 1 before the first tick. Expect `timerSync` pulse, `sdiBusy` to drop after the tick, no `serinRdy`, and `serinData` unchanged.
- **Framing error.** Send 0x3C with stop=0. Expect `serinData`=0x3C, `serinRdy` and `setFramer` pulsing in the same cycle, and `sdiOvrun`=0.
- **Overrun.** Send 0x11, no `irqAck`, then send 0x22. Expect a `sdiOvrun` pulse on the second completion and `serinData`=0x22. After `irqAck`, a third byte gives no overrun.
- **Simultaneous ack.** With a byte pending, assert `irqAck` in the STOP tick cycle of the next byte. Expect no `sdiOvrun` and the pending flag set (a following byte without ack overruns).
- **Reset mid-frame.** Pulse `reset` after 4 data ticks. Expect next cycle: `sdiBusy`=0, `serinData`=0x00, `siDelay`=1. A subsequent full frame of 0x5A is received correctly.
